// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: synchronous instruction-memory read port plus the
// valid/ready instruction stream presented to the decoder.
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 9
);
  logic                   imem_en;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]    instr_pc;
  logic                   instr_valid;
  logic                   instr_ready;

  modport master (
    output imem_en, imem_addr, instr, instr_pc, instr_valid,
    input  imem_rdata, instr_ready
  );

  modport slave (
    input  imem_en, imem_addr, instr, instr_pc, instr_valid,
    output imem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding reads to a 1-cycle memory,
// prefetch FIFO toward the decoder, redirect flush and HALT predecode.
//
// state | meaning
// IDLE  | after reset; waiting for start
// RUN   | fetching; issues reads while the FIFO has room
// DRAIN | HALT received; no more fetches, waiting for the decoder to take it
// DONE  | HALT accepted by decoder; done held until the next start
module instr_fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 9,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_addr,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic                busy,
  output logic                done,
  instr_fetch_unit_if.master  bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]   DEPTH_OCC = FIFO_DEPTH[CNT_W:0];
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [PC_WIDTH-1:0]    pc;
  logic                   inflight;
  logic                   discard;
  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       rd_ptr, wr_ptr;
  logic [INSTR_WIDTH-1:0] fifo_instr [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    fifo_pc    [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    rsp_pc;

  logic           start_act, redir_act, push, pop, halt_rsp, head_halt, issue;
  logic [CNT_W:0] occ;

  function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] w);
    return (w[INSTR_WIDTH-1 -: 3] == 3'b111) && (w[1:0] == 2'b11);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign start_act = start & ((state == S_IDLE) | (state == S_DONE));
  assign redir_act = redirect & ((state == S_RUN) | (state == S_DRAIN));
  assign pop       = bus.instr_valid & bus.instr_ready;
  // A response arriving in a redirect cycle belongs to the old path.
  assign push      = inflight & ~discard & ~redir_act & (state == S_RUN);
  assign halt_rsp  = push & is_halt(bus.imem_rdata);
  assign head_halt = is_halt(fifo_instr[rd_ptr]);
  assign occ       = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign issue     = (state == S_RUN) & ~redir_act & ~halt_rsp &
                     ((occ < DEPTH_OCC) | pop);

  assign bus.imem_en     = issue;
  assign bus.imem_addr   = pc;
  assign bus.instr       = fifo_instr[rd_ptr];
  assign bus.instr_pc    = fifo_pc[rd_ptr];
  assign bus.instr_valid = (count != '0);
  assign busy            = (state == S_RUN) | (state == S_DRAIN);
  assign done            = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (redir_act)     state_nxt = S_RUN;
        else if (halt_rsp) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (redir_act)             state_nxt = S_RUN;
        else if (pop && head_halt) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      rsp_pc   <= '0;
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      if (start_act)      pc <= start_addr;
      else if (redir_act) pc <= redirect_target;
      else if (issue)     pc <= pc + PC_WIDTH'(1);
      if (issue) rsp_pc <= pc;
      inflight <= issue;
      discard  <= redir_act & inflight & ~start_act;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (start_act || redir_act) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= bus.imem_rdata;
        fifo_pc[wr_ptr]    <= rsp_pc;
        wr_ptr             <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle synchronous memory model
// whose word at address a is a, except where a test plants a HALT.
module tb_instr_fetch_unit;
  localparam int PC_WIDTH    = 8;
  localparam int INSTR_WIDTH = 9;
  localparam int FIFO_DEPTH  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       redirect = 1'b0;
  logic [7:0] start_addr = 8'h00;
  logic [7:0] redirect_target = 8'h00;
  logic       busy, done;

  instr_fetch_unit_if #(.PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH)) bus ();

  instr_fetch_unit #(
    .PC_WIDTH(PC_WIDTH), .INSTR_WIDTH(INSTR_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .start_addr(start_addr),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .busy(busy),
    .done(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [8:0] mem [256];
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

  logic [7:0] pop_pc_q[$];
  logic [8:0] pop_instr_q[$];
  logic       saw_13 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.instr_valid && bus.instr_ready) begin
        pop_pc_q.push_back(bus.instr_pc);
        pop_instr_q.push_back(bus.instr);
      end
      if (bus.imem_en && bus.imem_addr == 8'h13) saw_13 = 1'b1;
      if (dut.push && !dut.pop && int'(dut.count) == FIFO_DEPTH)
        $error("prefetch FIFO overflow");
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    pop_pc_q.delete();
    pop_instr_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_start(input logic [7:0] a);
    start_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Delivered stream must be base, base+1, ... with the default memory image.
  task automatic check_pops(input string tag, input int base, input int n);
    check($sformatf("%s_npops", tag), 32'(pop_pc_q.size() >= n), 1);
    for (int i = 0; i < n && i < pop_pc_q.size(); i++) begin
      check($sformatf("%s_pc%0d", tag, i), 32'(pop_pc_q[i]), 32'((base + i) & 255));
      check($sformatf("%s_in%0d", tag, i), 32'(pop_instr_q[i]), 32'((base + i) & 255));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 9'(i);
    bus.instr_ready = 1'b1;

    // reset values, asserted without a clock edge
    rst_n = 1'b0;
    #2;
    check("rst_en",    32'(bus.imem_en), 0);
    check("rst_addr",  32'(bus.imem_addr), 0);
    check("rst_valid", 32'(bus.instr_valid), 0);
    check("rst_instr", 32'(bus.instr), 0);
    check("rst_pc",    32'(bus.instr_pc), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);

    // streaming, then backpressure
    do_reset();
    clear_q();
    do_start(8'h10);
    check("t1_en0",   32'(bus.imem_en), 1);
    check("t1_addr0", 32'(bus.imem_addr), 'h10);
    check("t1_val0",  32'(bus.instr_valid), 0);
    check("t1_busy",  32'(busy), 1);
    tick();
    check("t1_val1",  32'(bus.instr_valid), 0);
    tick();
    check("t1_val2",  32'(bus.instr_valid), 1);
    check("t1_ins2",  32'(bus.instr), 'h010);
    check("t1_pc2",   32'(bus.instr_pc), 'h10);
    tick();
    check("t1_pc3",   32'(bus.instr_pc), 'h11);
    tick();
    check("t1_pc4",   32'(bus.instr_pc), 'h12);
    bus.instr_ready = 1'b0;
    #1;
    check("t2_stall_en", 32'(bus.imem_en), 0);
    repeat (5) tick();
    check("t2_hold_en",  32'(bus.imem_en), 0);
    check("t2_hold_val", 32'(bus.instr_valid), 1);
    check("t2_hold_pc",  32'(bus.instr_pc), 'h12);
    bus.instr_ready = 1'b1;
    repeat (8) tick();
    check_pops("t2", 'h10, 10);

    // redirect with one entry buffered and a response in flight
    do_reset();
    bus.instr_ready = 1'b0;
    do_start(8'h10);
    repeat (3) tick();
    check("t3_full_en",  32'(bus.imem_en), 0);
    check("t3_full_pc",  32'(bus.instr_pc), 'h10);
    bus.instr_ready = 1'b1;
    #1;
    check("t3_pop_en",   32'(bus.imem_en), 1);
    check("t3_pop_addr", 32'(bus.imem_addr), 'h12);
    tick();
    bus.instr_ready = 1'b0;
    redirect_target = 8'h40;
    redirect = 1'b1;
    #1;
    check("t3_redir_en", 32'(bus.imem_en), 0);
    tick();
    redirect = 1'b0;
    #1;
    check("t3_r0_val",  32'(bus.instr_valid), 0);
    check("t3_r0_en",   32'(bus.imem_en), 1);
    check("t3_r0_addr", 32'(bus.imem_addr), 'h40);
    clear_q();
    bus.instr_ready = 1'b1;
    tick();
    check("t3_r1_val",  32'(bus.instr_valid), 0);
    tick();
    check("t3_r2_val",  32'(bus.instr_valid), 1);
    check("t3_r2_pc",   32'(bus.instr_pc), 'h40);
    repeat (4) tick();
    check_pops("t3", 'h40, 4);

    // PC wrap, then asynchronous reset mid-run
    do_reset();
    clear_q();
    bus.instr_ready = 1'b1;
    do_start(8'hFE);
    repeat (5) tick();
    check_pops("t6", 'hFE, 3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_val",  32'(bus.instr_valid), 0);
    check("t6_rst_en",   32'(bus.imem_en), 0);
    check("t6_rst_addr", 32'(bus.imem_addr), 0);
    check("t6_rst_busy", 32'(busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_idle_val", 32'(bus.instr_valid), 0);
    check("t6_idle_en",  32'(bus.imem_en), 0);
    redirect_target = 8'h55;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    check("t6_ign_busy", 32'(busy), 0);
    check("t6_ign_addr", 32'(bus.imem_addr), 0);

    // HALT at 0x12 reaches the decoder
    mem[8'h12] = 9'b111000011;
    do_reset();
    clear_q();
    saw_13 = 1'b0;
    bus.instr_ready = 1'b1;
    do_start(8'h10);
    repeat (4) tick();
    check("t4_h_val",   32'(bus.instr_valid), 1);
    check("t4_h_ins",   32'(bus.instr), 'h1C3);
    check("t4_h_pc",    32'(bus.instr_pc), 'h12);
    check("t4_h_done",  32'(done), 0);
    check("t4_h_en",    32'(bus.imem_en), 0);
    tick();
    check("t4_done",    32'(done), 1);
    check("t4_busy",    32'(busy), 0);
    check("t4_val",     32'(bus.instr_valid), 0);
    repeat (3) tick();
    check("t4_hold",    32'(done), 1);
    check("t4_no_0x13", 32'(saw_13), 0);

    // HALT buffered, then redirected away before the decoder takes it
    do_reset();
    clear_q();
    bus.instr_ready = 1'b0;
    do_start(8'h12);
    check("t5_addr0",  32'(bus.imem_addr), 'h12);
    tick();
    check("t5_h_en",   32'(bus.imem_en), 0);
    tick();
    check("t5_h_val",  32'(bus.instr_valid), 1);
    check("t5_h_ins",  32'(bus.instr), 'h1C3);
    redirect_target = 8'h20;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    check("t5_busy",   32'(busy), 1);
    check("t5_done",   32'(done), 0);
    check("t5_val",    32'(bus.instr_valid), 0);
    check("t5_en",     32'(bus.imem_en), 1);
    check("t5_addr",   32'(bus.imem_addr), 'h20);
    clear_q();
    bus.instr_ready = 1'b1;
    repeat (5) tick();
    check_pops("t5", 'h20, 3);
    check("t5_done_end", 32'(done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
